morse_key_sequencer: RTL and testbench

- Front-end controller for the Morse letter detector.
- Converts a raw telegraph-key line into timed dot, dash and end-of-letter codes.
- Pulses each code to the detector for exactly one cycle, then captures the resulting 7-segment glyph.
- Hands the glyph downstream over a valid/ready handshake.

---
 rtl/morse_pkg.sv | 29 ++
 rtl/morse_unit_timer.sv | 48 ++++
 rtl/morse_key_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_morse_key_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// morse_pkg: shared constants for the Morse key sequencer.
//   - FSM state encodings (legacy-compatible localparams)
//   - detector code values (idle / dot / dash / end-of-letter)
//   - error glyph shown when a letter had too many symbols
//   - unit-counter width and saturation value
//   - sym_code(): maps the dot/dash decision onto a detector code
package morse_pkg;

   localparam int unsigned UNIT_W = 4;
   localparam logic [UNIT_W-1:0] UNIT_MAX = 4'd15;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_PRESS = 3'd1;
   localparam logic [2:0] ST_GAP   = 3'd2;
   localparam logic [2:0] ST_SYM   = 3'd3;
   localparam logic [2:0] ST_END   = 3'd4;

   localparam logic [1:0] MCD_IDLE = 2'b00;
   localparam logic [1:0] MCD_DOT  = 2'b01;
   localparam logic [1:0] MCD_DASH = 2'b10;
   localparam logic [1:0] MCD_END  = 2'b11;

   localparam logic [6:0] ERR_GLYPH = 7'b0000001;

   function automatic logic [1:0] sym_code(input logic is_dash);
      return is_dash ? MCD_DASH : MCD_DOT;
   endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// morse_unit_timer: prescaler plus saturating Morse unit counter.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   clear       - restart prescaler and zero the unit counter
//   tick        - one-cycle pulse every TICK_DIV clocks
//   units       - elapsed units since the last clear, saturating at UNIT_MAX
module morse_unit_timer
   import morse_pkg::*;
#(
   parameter int unsigned TICK_DIV = 1000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   output logic              tick,
   output logic [UNIT_W-1:0] units
);

   localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

   logic [PRESC_W-1:0] presc_q, presc_d;
   logic [UNIT_W-1:0]  units_q, units_d;

   always_comb begin
      tick    = !clear && (presc_q == PRESC_LAST);
      presc_d = (clear || tick) ? '0 : presc_q + PRESC_W'(1);
      units_d = units_q;
      if (clear) begin
         units_d = '0;
      end else if (tick && (units_q != UNIT_MAX)) begin
         units_d = units_q + UNIT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc_q <= '0;
         units_q <= '0;
      end else begin
         presc_q <= presc_d;
         units_q <= units_d;
      end
   end

   assign units = units_q;

endmodule

// File: rtl/morse_key_sequencer.sv
// morse_key_sequencer: turns a raw telegraph-key line into timed dot / dash /
// end-of-letter codes for the Morse letter detector, captures the resulting
// glyph and offers it downstream over valid/ready.
// Ports:
//   clk, reset       - clock, asynchronous active-high reset
//   enable           - run enable; dropping it aborts a letter in progress
//   key_in           - raw asynchronous key line, 1 = pressed
//   mcd_code         - registered code to detector (00/01/10/11)
//   mcd_seg          - detector glyph, sampled while END drives 11
//   letter_valid/letter_seg/letter_ready - downstream handshake
//   sym_overflow     - pulse: symbol dropped, letter had too many symbols
//   letter_overrun   - pulse: an unconsumed letter was overwritten
//   busy             - FSM not idle
// Build option: define MORSE_DEBOUNCE_EN to insert a DEB_CYCLES stability
// filter between the synchronizer and the FSM.
module morse_key_sequencer
   import morse_pkg::*;
#(
   parameter int unsigned TICK_DIV   = 1000,
   parameter int unsigned DASH_UNITS = 2,
   parameter int unsigned GAP_UNITS  = 3,
   parameter int unsigned MAX_SYMS   = 4,
   parameter int unsigned DEB_CYCLES = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       key_in,
   output logic [1:0] mcd_code,
   input  logic [6:0] mcd_seg,
   output logic       letter_valid,
   output logic [6:0] letter_seg,
   input  logic       letter_ready,
   output logic       sym_overflow,
   output logic       letter_overrun,
   output logic       busy
);

   localparam int unsigned SYM_W = $clog2(MAX_SYMS + 1);
   localparam logic [SYM_W-1:0]  SYM_LIMIT = SYM_W'(MAX_SYMS);
   localparam logic [UNIT_W-1:0] DASH_LIM  = UNIT_W'(DASH_UNITS);
   localparam logic [UNIT_W-1:0] GAP_LIM   = UNIT_W'(GAP_UNITS);

   logic key_s1_q, key_s2_q, key_prev_q;
   logic key_fsm, key_edge;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         key_s1_q <= 1'b0;
         key_s2_q <= 1'b0;
      end else begin
         key_s1_q <= key_in;
         key_s2_q <= key_s1_q;
      end
   end

`ifdef MORSE_DEBOUNCE_EN
   localparam int unsigned DEB_W = $clog2(DEB_CYCLES + 1);
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

   logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
   logic             key_deb_q, key_deb_d;

   // Count consecutive cycles the synchronized key disagrees with the filtered
   // value; any agreement restarts the window.
   always_comb begin
      deb_cnt_d = '0;
      key_deb_d = key_deb_q;
      if (key_s2_q != key_deb_q) begin
         if (deb_cnt_q == DEB_LAST) begin
            key_deb_d = key_s2_q;
         end else begin
            deb_cnt_d = deb_cnt_q + DEB_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         deb_cnt_q <= '0;
         key_deb_q <= 1'b0;
      end else begin
         deb_cnt_q <= deb_cnt_d;
         key_deb_q <= key_deb_d;
      end
   end

   assign key_fsm = key_deb_q;
`else
   assign key_fsm = key_s2_q;
`endif

   assign key_edge = key_fsm ^ key_prev_q;

   logic [2:0]        state_q, state_d;
   logic [SYM_W-1:0]  sym_cnt_q, sym_cnt_d;
   logic              err_q, err_d;
   logic [1:0]        mcd_code_q, mcd_code_d;
   logic              valid_q, valid_d;
   logic [6:0]        seg_q, seg_d;
   logic              ovf_q, ovf_d;
   logic              ovr_q, ovr_d;
   logic              fsm_clr, abort;
   logic              unit_tick;
   logic [UNIT_W-1:0] units;

   morse_unit_timer #(
      .TICK_DIV(TICK_DIV)
   ) u_timer (
      .clk  (clk),
      .reset(reset),
      .clear(fsm_clr | key_edge),
      .tick (unit_tick),
      .units(units)
   );

   // Only PRESS/GAP can be interrupted; SYM and END finish their single-cycle
   // code first so two non-idle codes are never driven back to back.
   assign abort = !enable && ((state_q == ST_PRESS) || (state_q == ST_GAP));

   always_comb begin
      state_d    = state_q;
      sym_cnt_d  = sym_cnt_q;
      err_d      = err_q;
      mcd_code_d = MCD_IDLE;
      valid_d    = valid_q && !letter_ready;
      seg_d      = seg_q;
      ovf_d      = 1'b0;
      ovr_d      = 1'b0;
      fsm_clr    = 1'b0;
      if (abort) begin
         // Return the detector to its root state without capturing a glyph.
         if (sym_cnt_q != '0) begin
            mcd_code_d = MCD_END;
         end
         sym_cnt_d = '0;
         err_d     = 1'b0;
         state_d   = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (enable && key_fsm) begin
                  state_d = ST_PRESS;
                  fsm_clr = 1'b1;
               end
            end
            ST_PRESS: begin
               if (!key_fsm) begin
                  if (sym_cnt_q < SYM_LIMIT) begin
                     mcd_code_d = sym_code(units >= DASH_LIM);
                     sym_cnt_d  = sym_cnt_q + SYM_W'(1);
                     state_d    = ST_SYM;
                  end else begin
                     ovf_d   = 1'b1;
                     err_d   = 1'b1;
                     state_d = ST_GAP;
                     fsm_clr = 1'b1;
                  end
               end
            end
            ST_SYM: begin
               state_d = ST_GAP;
               fsm_clr = 1'b1;
            end
            ST_GAP: begin
               if (units >= GAP_LIM) begin
                  mcd_code_d = MCD_END;
                  state_d    = ST_END;
               end else if (key_fsm) begin
                  state_d = ST_PRESS;
                  fsm_clr = 1'b1;
               end
            end
            ST_END: begin
               seg_d     = err_q ? ERR_GLYPH : mcd_seg;
               valid_d   = 1'b1;
               // Acceptance in this same cycle frees the slot: no overrun.
               ovr_d     = valid_q && !letter_ready;
               sym_cnt_d = '0;
               err_d     = 1'b0;
               state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         key_prev_q <= 1'b0;
         state_q    <= ST_IDLE;
         sym_cnt_q  <= '0;
         err_q      <= 1'b0;
         mcd_code_q <= MCD_IDLE;
         valid_q    <= 1'b0;
         seg_q      <= '0;
         ovf_q      <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         key_prev_q <= key_fsm;
         state_q    <= state_d;
         sym_cnt_q  <= sym_cnt_d;
         err_q      <= err_d;
         mcd_code_q <= mcd_code_d;
         valid_q    <= valid_d;
         seg_q      <= seg_d;
         ovf_q      <= ovf_d;
         ovr_q      <= ovr_d;
      end
   end

   assign mcd_code       = mcd_code_q;
   assign letter_valid   = valid_q;
   assign letter_seg     = seg_q;
   assign sym_overflow   = ovf_q;
   assign letter_overrun = ovr_q;
   assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_morse_key_sequencer.sv
// tb_morse_key_sequencer: directed, self-checking bench for morse_key_sequencer
// with TICK_DIV=4. A negedge monitor logs every non-idle detector code and
// counts pulse cycles; scenarios compare against hand-computed values.
module tb_morse_key_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic       key_in;
   logic [1:0] mcd_code;
   logic [6:0] mcd_seg;
   logic       letter_valid;
   logic [6:0] letter_seg;
   logic       letter_ready;
   logic       sym_overflow;
   logic       letter_overrun;
   logic       busy;

   int n_cmp = 0;
   int n_bad = 0;

   logic [1:0] codes[$];
   logic [1:0] prev_code = 2'b00;
   int         b2b_cnt = 0;
   int         ovf_cycles = 0;
   int         ovr_cycles = 0;
   int         base;
   int         ovf_base;
   int         ovr_base;

   always #5 clk = ~clk;

   morse_key_sequencer #(
      .TICK_DIV  (4),
      .DASH_UNITS(2),
      .GAP_UNITS (3),
      .MAX_SYMS  (4),
      .DEB_CYCLES(16)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .enable        (enable),
      .key_in        (key_in),
      .mcd_code      (mcd_code),
      .mcd_seg       (mcd_seg),
      .letter_valid  (letter_valid),
      .letter_seg    (letter_seg),
      .letter_ready  (letter_ready),
      .sym_overflow  (sym_overflow),
      .letter_overrun(letter_overrun),
      .busy          (busy)
   );

   always @(negedge clk) begin
      if (!reset) begin
         if (mcd_code != 2'b00) codes.push_back(mcd_code);
         if ((mcd_code != 2'b00) && (prev_code != 2'b00)) b2b_cnt++;
         prev_code = mcd_code;
         if (sym_overflow) ovf_cycles++;
         if (letter_overrun) ovr_cycles++;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press(input int n);
      key_in = 1'b1;
      step(n);
      key_in = 1'b0;
   endtask

   task automatic consume();
      letter_ready = 1'b1;
      step(1);
      letter_ready = 1'b0;
   endtask

   task automatic mark();
      base     = codes.size();
      ovf_base = ovf_cycles;
      ovr_base = ovr_cycles;
   endtask

   // exp packs codes with the first one in bits [1:0].
   task automatic check_codes(input string tag, input int n, input logic [11:0] exp);
      check_eq({tag, "_ncodes"}, codes.size() - base, n);
      for (int i = 0; i < n; i++) begin
         if (base + i < codes.size())
            check_eq($sformatf("%s_code%0d", tag, i), codes[base + i], exp[2*i +: 2]);
      end
   endtask

   initial begin
      reset        = 1'b1;
      enable       = 1'b1;
      key_in       = 1'b0;
      mcd_seg      = 7'b0;
      letter_ready = 1'b0;
      step(3);
      check_eq("rst_code", mcd_code, 2'b00);
      check_eq("rst_valid", letter_valid, 1'b0);
      check_eq("rst_seg", letter_seg, 7'b0);
      check_eq("rst_ovf", sym_overflow, 1'b0);
      check_eq("rst_ovr", letter_overrun, 1'b0);
      check_eq("rst_busy", busy, 1'b0);
      reset = 1'b0;
      step(2);

`ifdef MORSE_DEBOUNCE_EN
      // 3-clock glitch is shorter than the stability window.
      mark();
      press(3);
      step(40);
      check_codes("glitch", 0, 12'h000);
      check_eq("glitch_busy", busy, 1'b0);
      check_eq("glitch_valid", letter_valid, 1'b0);

      // 20-clock press survives the filter: ~4 units -> dash.
      mark();
      mcd_seg = 7'b0001111;
      press(20);
      step(80);
      check_codes("deb_t", 2, {2'b11, 2'b10});
      check_eq("deb_t_seg", letter_seg, 7'b0001111);
      check_eq("deb_t_valid", letter_valid, 1'b1);
`else
      // Letter E: one dot.
      mark();
      mcd_seg = 7'b1001111;
      press(4);
      step(40);
      check_codes("e", 2, {2'b11, 2'b01});
      check_eq("e_seg", letter_seg, 7'b1001111);
      check_eq("e_valid", letter_valid, 1'b1);
      check_eq("e_busy", busy, 1'b0);
      consume();
      check_eq("e_consumed", letter_valid, 1'b0);

      // Letter N: dash, dot.
      mark();
      mcd_seg = 7'b0010101;
      press(12);
      step(4);
      press(4);
      step(40);
      check_codes("n", 3, {2'b11, 2'b01, 2'b10});
      check_eq("n_seg", letter_seg, 7'b0010101);
      check_eq("n_valid", letter_valid, 1'b1);
      consume();

      // Five dots: the fifth overflows and the letter shows the error glyph.
      mark();
      mcd_seg = 7'b1111111;
      for (int i = 0; i < 5; i++) begin
         press(4);
         step(4);
      end
      step(40);
      check_codes("ovf", 5, {2'b11, 2'b01, 2'b01, 2'b01, 2'b01});
      check_eq("ovf_pulse", ovf_cycles - ovf_base, 1);
      check_eq("ovf_seg", letter_seg, 7'b0000001);
      check_eq("ovf_valid", letter_valid, 1'b1);
      check_eq("ovf_no_ovr", ovr_cycles - ovr_base, 0);
      consume();

      // Two letters without ready: the second overwrites the first.
      mark();
      mcd_seg = 7'b1001111;
      press(4);
      step(40);
      check_eq("ovr_first_seg", letter_seg, 7'b1001111);
      check_eq("ovr_first_none", ovr_cycles - ovr_base, 0);
      mcd_seg = 7'b0001111;
      press(12);
      step(40);
      check_eq("ovr_pulse", ovr_cycles - ovr_base, 1);
      check_eq("ovr_seg", letter_seg, 7'b0001111);
      check_eq("ovr_valid", letter_valid, 1'b1);
      consume();
      check_eq("ovr_consumed", letter_valid, 1'b0);

      // Abort after one dash: a single 11, no capture, key ignored while low.
      mark();
      mcd_seg = 7'b1010101;
      press(12);
      step(6);
      check_eq("abort_busy_before", busy, 1'b1);
      enable = 1'b0;
      step(3);
      press(6);
      step(40);
      check_codes("abort", 2, {2'b11, 2'b10});
      check_eq("abort_valid", letter_valid, 1'b0);
      check_eq("abort_busy", busy, 1'b0);
      enable = 1'b1;
      step(3);

      // Reset asserted mid-press clears outputs without waiting for a clock.
      mcd_seg = 7'b1001111;
      press(4);
      step(40);
      check_eq("rst2_valid_before", letter_valid, 1'b1);
      key_in = 1'b1;
      step(6);
      check_eq("rst2_busy_before", busy, 1'b1);
      #2;
      reset = 1'b1;
      #1;
      check_eq("rst2_valid", letter_valid, 1'b0);
      check_eq("rst2_seg", letter_seg, 7'b0);
      check_eq("rst2_busy", busy, 1'b0);
      check_eq("rst2_code", mcd_code, 2'b00);
      key_in = 1'b0;
      step(2);
      reset = 1'b0;
      step(2);
`endif

      check_eq("no_back_to_back_codes", b2b_cnt, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
